multicycle_control: RTL and testbench

Multi-cycle sequencer for the MIPS-subset datapath: decodes `opcode` once per instruction and steps the shared ALU, register file, PC and unified instruction/data memory through fetch, decode, execute, memory and write-back cycles. Memory accesses use a `mem_req`/`mem_ready` handshake with a bounded wait. It supports the same instruction set as the single-cycle control decoder (R-type, lw, sw, beq, j) and replaces it when the datapath runs multi-cycle.

---
 rtl/control_pkg.sv | 46 ++++
 rtl/multicycle_control_if.sv | 35 +++
 rtl/mem_wait_timer.sv | 25 ++
 rtl/multicycle_control.sv | 115 +++++++++++
 tb/tb_multicycle_control.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// control_pkg: opcodes, FSM state encoding and datapath select codes shared by the
// single-cycle decoder, the multi-cycle sequencer and the ALU control.
package control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic opcode_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

    // States that hold mem_req high and wait on mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return s inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control-to-datapath bundle; master is the sequencer, slave the datapath.
interface multicycle_control_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op;
    logic       bus_error;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_source, state, illegal_op, bus_error
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_source, state, illegal_op, bus_error
    );

endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory wait cycles; expired flags the last allowed one.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (count_en)
            count <= count + W'(1);
    end

    assign expired = count_en && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS-subset sequencer (fetch/decode/execute/mem/write-back)
// with a bounded mem_req/mem_ready wait that aborts to FETCH with a bus_error pulse.
module multicycle_control
    import control_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t state_q, state_d;
    logic   waiting, expired;

    assign waiting = is_wait_state(state_q) && !bus.mem_ready;

    // Timer restarts on every state change and after each timeout, so a refetch gets a full budget.
    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_d != state_q || expired),
        .count_en (waiting),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        state_q <= reset ? S_FETCH : state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = (bus.opcode == OP_RTYPE) ? S_R_EXEC :
                                   (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEM_ADDR :
                                   (bus.opcode == OP_BEQ) ? S_BRANCH :
                                   (bus.opcode == OP_J) ? S_JUMP : S_FETCH;
            S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : expired ? S_FETCH : S_MEM_READ;
            S_MEM_WRITE: state_d = (bus.mem_ready || expired) ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_B;
        bus.alu_op     = ALU_ADD;
        bus.pc_source  = PC_ALU;
        bus.illegal_op = 1'b0;
        bus.bus_error  = !reset && expired;
        bus.state      = reset ? 4'd0 : state_q;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b  = SRCB_IMM_SH;
                    bus.illegal_op = !opcode_legal(bus.opcode);
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MEM_READ: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    bus.mem_we  = !expired;
                end
                S_R_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_SUB;
                    bus.pc_source = PC_ALUOUT;
                    bus.pc_write  = bus.zero;
                end
                S_JUMP: begin
                    bus.pc_source = PC_JUMP;
                    bus.pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-instruction reference model queues expected per-cycle outputs;
// a negedge monitor pops and compares them against the sequencer.
module tb_multicycle_control;

    localparam int T = 16;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, iord, ir_write, pc_write;
        logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] src_b, alu_op, pc_src;
        logic       illegal, berr;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if ifc();
    multicycle_control #(.TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(ifc));

    rec_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   run = 1'b0;

    function automatic rec_t r0(input int st);
        rec_t r;
        r = '0;
        r.st = 4'(st);
        return r;
    endfunction

    function automatic rec_t act();
        rec_t a;
        a.st = ifc.state;             a.mem_req = ifc.mem_req;     a.mem_we = ifc.mem_we;
        a.iord = ifc.iord;            a.ir_write = ifc.ir_write;   a.pc_write = ifc.pc_write;
        a.reg_write = ifc.reg_write;  a.reg_dst = ifc.reg_dst;     a.mem_to_reg = ifc.mem_to_reg;
        a.alu_src_a = ifc.alu_src_a;  a.src_b = ifc.alu_src_b;     a.alu_op = ifc.alu_op;
        a.pc_src = ifc.pc_source;     a.illegal = ifc.illegal_op;  a.berr = ifc.bus_error;
        return a;
    endfunction

    always @(negedge clk) begin
        if (run) begin
            rec_t a, e;
            a = act();
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow t=%0t got=%h required=none", $time, a);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t exp_state=%0d got=%h required=%h", $time, e.st, a, e);
                end
            end
        end
    end

    task automatic cyc(input rec_t e, input logic rdy);
        ifc.mem_ready = rdy;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic stray();
        return 1'($urandom_range(0, 1));
    endfunction

    // r = number of not-ready cycles before memory answers; every T-th consecutive one times out.
    task automatic fetch(input int r);
        rec_t e;
        int w = 0;
        while (r > 0) begin
            e = r0(0); e.mem_req = 1; e.src_b = 2'b01;
            if (w == T - 1) begin e.berr = 1; w = 0; end else w++;
            cyc(e, 1'b0);
            r--;
        end
        e = r0(0); e.mem_req = 1; e.src_b = 2'b01; e.ir_write = 1; e.pc_write = 1;
        cyc(e, 1'b1);
    endtask

    task automatic data(input int st, input logic we, input int r, output bit ok);
        rec_t e;
        int w = 0;
        ok = 1'b1;
        while (r > 0) begin
            e = r0(st); e.mem_req = 1; e.iord = 1; e.mem_we = we;
            if (w == T - 1) begin
                e.berr = 1; e.mem_we = 0;
                cyc(e, 1'b0);
                ok = 1'b0;
                return;
            end
            w++;
            cyc(e, 1'b0);
            r--;
        end
        e = r0(st); e.mem_req = 1; e.iord = 1; e.mem_we = we;
        cyc(e, 1'b1);
    endtask

    task automatic instr(input logic [5:0] op, input logic z, input int fw, input int dw);
        rec_t e;
        bit   ok, legal;
        ifc.opcode = op;
        ifc.zero = z;
        fetch(fw);
        legal = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        e = r0(1); e.src_b = 2'b11; e.illegal = !legal;
        cyc(e, stray());
        if (!legal) return;
        case (op)
            6'b000000: begin
                e = r0(6); e.alu_src_a = 1; e.alu_op = 2'b10; cyc(e, stray());
                e = r0(7); e.reg_write = 1; e.reg_dst = 1;    cyc(e, stray());
            end
            6'b100011, 6'b101011: begin
                e = r0(2); e.alu_src_a = 1; e.src_b = 2'b10; cyc(e, stray());
                data(op == 6'b100011 ? 3 : 5, op == 6'b101011, dw, ok);
                if (ok && op == 6'b100011) begin
                    e = r0(4); e.reg_write = 1; e.mem_to_reg = 1; cyc(e, stray());
                end
            end
            6'b000100: begin
                e = r0(8); e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_write = z;
                cyc(e, stray());
            end
            default: begin
                e = r0(9); e.pc_src = 2'b10; e.pc_write = 1; cyc(e, stray());
            end
        endcase
    endtask

    initial begin
        logic [5:0] ops [5];
        logic [5:0] op;
        rec_t e;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b000010;
        ifc.opcode = '0;
        ifc.zero = 1'b0;
        ifc.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b1;
        for (int i = 0; i < 3; i++) cyc(r0(0), 1'b1);
        reset = 1'b0;
        instr(6'b000000, 1'b0, 0, 0);
        instr(6'b100011, 1'b0, 0, 2);
        instr(6'b000100, 1'b1, 0, 0);
        instr(6'b000100, 1'b0, 0, 0);
        instr(6'b101011, 1'b0, 1, 1);
        instr(6'b111111, 1'b0, 0, 0);
        instr(6'b000010, 1'b0, 0, 0);
        instr(6'b000000, 1'b0, 18, 0);
        instr(6'b100011, 1'b0, 0, 20);
        instr(6'b101011, 1'b0, 0, 15);
        // reset lands in a MEM_WRITE wait with a pending mem_ready that must be ignored
        ifc.opcode = 6'b101011;
        fetch(0);
        e = r0(1); e.src_b = 2'b11;                  cyc(e, 1'b0);
        e = r0(2); e.alu_src_a = 1; e.src_b = 2'b10; cyc(e, 1'b0);
        e = r0(5); e.mem_req = 1; e.iord = 1; e.mem_we = 1; cyc(e, 1'b0);
        reset = 1'b1;
        cyc(r0(0), 1'b1);
        reset = 1'b0;
        instr(6'b000010, 1'b0, 0, 0);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 5) begin
                do op = 6'($urandom); while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010});
            end else
                op = ops[$urandom_range(0, 4)];
            instr(op, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 17 : $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 3));
        end
        run = 1'b0;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
